param_return_stack: RTL and testbench

- Parametrised hardware return-address stack for the 4-bit MCU core family; next generation of the fixed 5-deep × 10-bit shift-register subroutine stack.
- Adds configurable width and depth, an occupancy count, full/empty status, sticky overflow/underflow flags, a selectable overflow policy, a replace-top (tail-call) operation, and a synchronous flush.
- Sits beside the program counter: CALL pushes the PC, RET/RETSK pops into the PC, and the top of stack is always visible combinationally.

---
 rtl/rs_pkg.sv | 10 +
 rtl/rs_stage.sv | 25 ++
 rtl/param_return_stack.sv | 84 ++++++++
 tb/tb_param_return_stack.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// rs_pkg: op encodings, overflow policies and stage-mux selects for the return stack
package rs_pkg;
    localparam logic [1:0] RS_NOP  = 2'b00;
    localparam logic [1:0] RS_POP  = 2'b01;
    localparam logic [1:0] RS_PUSH = 2'b10;
    localparam logic [1:0] RS_REPL = 2'b11;
    localparam int RS_OVF_DROP   = 0;
    localparam int RS_OVF_REJECT = 1;
    typedef enum logic [2:0] {ST_HOLD, ST_DIN, ST_ABOVE, ST_BELOW, ST_CLR} stage_sel_e;
endpackage

// File: rtl/rs_stage.sv
// rs_stage: one stack entry register with hold/load-din/load-above/load-below/clear mux
module rs_stage
    import rs_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             RESET,
    input  stage_sel_e       sel,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] above,
    input  logic [WIDTH-1:0] below,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge RESET)
        if (!RESET) q <= '0;
        else
            case (sel)
                ST_DIN:   q <= din;
                ST_ABOVE: q <= above;
                ST_BELOW: q <= below;
                ST_CLR:   q <= '0;
                default:  q <= q;
            endcase
endmodule

// File: rtl/param_return_stack.sv
// param_return_stack: parametrised return-address stack with count, status and sticky error flags
module param_return_stack
    import rs_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int DEPTH    = 5,
    parameter int OVF_MODE = 0,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             en,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             flush,
    input  logic             err_clr,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);
    logic [WIDTH-1:0] stg [DEPTH];
    logic [1:0] op;
    logic reject, ovf_set, unf_set;
    logic [CNT_W-1:0] count_nxt;
    stage_sel_e sel_top, sel_rest;

    assign op      = {push, pop};
    assign full    = count == CNT_W'(DEPTH);
    assign empty   = count == '0;
    assign top     = stg[0];
    assign reject  = full && OVF_MODE == RS_OVF_REJECT;
    assign ovf_set = !flush && op == RS_PUSH && full;
    assign unf_set = !flush && pop && empty;

    // stage 0 takes din on push/replace; deeper stages only shift or hold
    assign sel_top  = !en ? ST_HOLD : flush ? ST_CLR : op == RS_POP ? ST_BELOW :
                      (op == RS_NOP || (op == RS_PUSH && reject)) ? ST_HOLD : ST_DIN;
    assign sel_rest = !en ? ST_HOLD : flush ? ST_CLR : op == RS_POP ? ST_BELOW :
                      (op == RS_PUSH && !reject) ? ST_ABOVE : ST_HOLD;

    assign count_nxt = flush ? '0 :
                       (op == RS_PUSH && !full) ? count + CNT_W'(1) :
                       (op == RS_POP && !empty) ? count - CNT_W'(1) :
                       (op == RS_REPL && empty) ? CNT_W'(1) : count;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] above, below;
        if (i == 0) begin : g_first
            assign above = din;
        end else begin : g_inner
            assign above = stg[i-1];
        end
        if (i == DEPTH - 1) begin : g_last
            assign below = '0;
        end else begin : g_deep
            assign below = stg[i+1];
        end
        rs_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .RESET (RESET),
            .sel   (i == 0 ? sel_top : sel_rest),
            .din   (din),
            .above (above),
            .below (below),
            .q     (stg[i])
        );
    end

    // a fresh overflow/underflow in the same cycle beats err_clr
    always_ff @(posedge clk or negedge RESET)
        if (!RESET) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (en) begin
            count <= count_nxt;
            ovf   <= ovf_set | (ovf & ~err_clr);
            unf   <= unf_set | (unf & ~err_clr);
        end
endmodule

// File: tb/tb_param_return_stack.sv
// tb_param_return_stack: table, directed and random checks of both overflow policies against a queue model
module tb_param_return_stack;
    localparam int D = 5;
    logic clk = 0, RESET = 0, en = 0, push = 0, pop = 0, flush = 0, err_clr = 0;
    logic [9:0] din = '0;
    logic [9:0] top0, top1;
    logic [2:0] count0, count1;
    logic empty0, empty1, full0, full1, ovf0, ovf1, unf0, unf1;
    int checks = 0, failures = 0;

    logic [9:0] mq [2][$];
    bit mov [2];
    bit mun [2];

    typedef struct {
        bit p, o, c;
        logic [9:0] d;
        logic [9:0] e_top;
        int e_cnt;
        bit e_ovf, e_unf;
    } vec_t;
    vec_t tbl [15];

    always #5 clk = ~clk;

    param_return_stack #(.WIDTH(10), .DEPTH(D), .OVF_MODE(0)) dut0 (
        .clk(clk), .RESET(RESET), .en(en), .push(push), .pop(pop), .din(din), .flush(flush),
        .err_clr(err_clr), .top(top0), .count(count0), .empty(empty0), .full(full0), .ovf(ovf0), .unf(unf0));
    param_return_stack #(.WIDTH(10), .DEPTH(D), .OVF_MODE(1)) dut1 (
        .clk(clk), .RESET(RESET), .en(en), .push(push), .pop(pop), .din(din), .flush(flush),
        .err_clr(err_clr), .top(top1), .count(count1), .empty(empty1), .full(full1), .ovf(ovf1), .unf(unf1));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            mov[m] = 0;
            mun[m] = 0;
        end
    endtask

    task automatic model_step();
        bit os, us;
        if (!en) return;
        for (int m = 0; m < 2; m++) begin
            os = 0;
            us = 0;
            if (flush) mq[m].delete();
            else if (push && !pop) begin
                if (mq[m].size() < D) mq[m].push_front(din);
                else begin
                    os = 1;
                    if (m == 0) begin
                        mq[m].push_front(din);
                        void'(mq[m].pop_back());
                    end
                end
            end else if (!push && pop) begin
                if (mq[m].size() > 0) void'(mq[m].pop_front());
                else us = 1;
            end else if (push && pop) begin
                if (mq[m].size() > 0) mq[m][0] = din;
                else begin
                    mq[m].push_front(din);
                    us = 1;
                end
            end
            mov[m] = os | (mov[m] & !err_clr);
            mun[m] = us | (mun[m] & !err_clr);
        end
    endtask

    task automatic model_check();
        int n0, n1;
        n0 = mq[0].size();
        n1 = mq[1].size();
        chk("top0", top0, n0 > 0 ? int'(mq[0][0]) : 0);
        chk("count0", count0, n0);
        chk("empty0", empty0, n0 == 0);
        chk("full0", full0, n0 == D);
        chk("ovf0", ovf0, mov[0]);
        chk("unf0", unf0, mun[0]);
        chk("top1", top1, n1 > 0 ? int'(mq[1][0]) : 0);
        chk("count1", count1, n1);
        chk("empty1", empty1, n1 == 0);
        chk("full1", full1, n1 == D);
        chk("ovf1", ovf1, mov[1]);
        chk("unf1", unf1, mun[1]);
    endtask

    task automatic cyc(input bit e, p, o, f, c, input logic [9:0] d);
        en = e; push = p; pop = o; flush = f; err_clr = c; din = d;
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    task automatic op(input bit p, o, c, input logic [9:0] d);
        cyc(1, p, o, 0, c, d);
    endtask

    initial begin
        tbl[0]  = '{1, 0, 0, 10'h012, 10'h012, 1, 0, 0};
        tbl[1]  = '{1, 0, 0, 10'h034, 10'h034, 2, 0, 0};
        tbl[2]  = '{1, 0, 0, 10'h056, 10'h056, 3, 0, 0};
        tbl[3]  = '{0, 1, 0, 10'h000, 10'h034, 2, 0, 0};
        tbl[4]  = '{0, 1, 0, 10'h000, 10'h012, 1, 0, 0};
        tbl[5]  = '{0, 1, 0, 10'h000, 10'h000, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 10'h000, 10'h000, 0, 0, 1};
        tbl[7]  = '{0, 0, 1, 10'h000, 10'h000, 0, 0, 0};
        tbl[8]  = '{0, 1, 1, 10'h000, 10'h000, 0, 0, 1};
        tbl[9]  = '{0, 0, 1, 10'h000, 10'h000, 0, 0, 0};
        tbl[10] = '{1, 0, 0, 10'h0AA, 10'h0AA, 1, 0, 0};
        tbl[11] = '{1, 0, 0, 10'h0BB, 10'h0BB, 2, 0, 0};
        tbl[12] = '{1, 1, 0, 10'h0CC, 10'h0CC, 2, 0, 0};
        tbl[13] = '{0, 1, 0, 10'h000, 10'h0AA, 1, 0, 0};
        tbl[14] = '{0, 1, 0, 10'h000, 10'h000, 0, 0, 0};

        model_reset();
        #3;
        model_check();
        RESET = 1;

        foreach (tbl[k]) begin
            op(tbl[k].p, tbl[k].o, tbl[k].c, tbl[k].d);
            chk($sformatf("tbl%0d_top0", k), top0, tbl[k].e_top);
            chk($sformatf("tbl%0d_top1", k), top1, tbl[k].e_top);
            chk($sformatf("tbl%0d_cnt0", k), count0, tbl[k].e_cnt);
            chk($sformatf("tbl%0d_cnt1", k), count1, tbl[k].e_cnt);
            chk($sformatf("tbl%0d_ovf", k), ovf0, tbl[k].e_ovf);
            chk($sformatf("tbl%0d_unf", k), unf1, tbl[k].e_unf);
        end

        // overflow: drop-oldest versus reject
        for (int k = 1; k <= 6; k++) op(1, 0, 0, 10'(k));
        chk("ovf_top0", top0, 6);
        chk("ovf_top1", top1, 5);
        chk("ovf_full0", full0, 1);
        chk("ovf_flag0", ovf0, 1);
        chk("ovf_flag1", ovf1, 1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("ovf_pop%0d_0", k), top0, 6 - k);
            chk($sformatf("ovf_pop%0d_1", k), top1, 5 - k);
            op(0, 1, 0, 0);
        end
        chk("ovf_drained", count0 + count1, 0);

        // en low freezes everything, sticky flags included
        op(0, 0, 1, 0);
        for (int k = 1; k <= 6; k++) op(1, 0, 0, 10'(k + 8));
        cyc(0, 1, 0, 0, 1, 10'h3FF);
        cyc(0, 0, 1, 1, 1, 10'h000);
        chk("hold_ovf0", ovf0, 1);
        chk("hold_top0", top0, 14);
        chk("hold_cnt1", count1, 5);

        // flush clears deeper stages too: push one and pop must expose zero
        cyc(1, 0, 0, 1, 0, 0);
        chk("flush_cnt", count0, 0);
        chk("flush_ovf_kept", ovf1, 1);
        op(1, 0, 0, 10'h111);
        op(0, 1, 0, 0);
        chk("flush_deep0", top0, 0);
        chk("flush_deep1", top1, 0);

        // asynchronous reset mid-sequence
        op(1, 0, 0, 10'h155);
        op(1, 0, 0, 10'h2AA);
        en = 1; push = 1; din = 10'h3C3;
        #2 RESET = 0;
        #1;
        model_reset();
        model_check();
        chk("async_top", top0, 0);
        #2 RESET = 1;

        // random traffic
        for (int k = 0; k < 600; k++)
            cyc($urandom_range(9) != 0, $urandom_range(1), $urandom_range(1),
                $urandom_range(31) == 0, $urandom_range(15) == 0, 10'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
